// File: rtl/clock_div_prog.sv
// Multi-channel programmable clock divider.
// Each channel divides clk_in by its own runtime-loadable divisor with a
// near-50% duty cycle and a one-cycle tick per output period. A newly loaded
// divisor waits as "pending" and is applied only at the channel's next period
// boundary, so the output never produces a runt pulse. An LED counter tracks
// channel-0 periods.
module clock_div_prog #(
  parameter int CHANNELS    = 2,
  parameter int DIV_W       = 16,
  parameter int DEFAULT_DIV = 4,
  parameter int LED_W       = 8,
  localparam int CH_W       = (CHANNELS > 1) ? $clog2(CHANNELS) : 1
) (
  input  logic                clk_in,
  input  logic                reset,
  input  logic                en,
  input  logic                load,
  input  logic [CH_W-1:0]     load_ch,
  input  logic [DIV_W-1:0]    load_div,
  output logic [CHANNELS-1:0] clk_out,
  output logic [CHANNELS-1:0] tick,
  output logic [CHANNELS-1:0] pending,
  output logic [LED_W-1:0]    leds
);

  localparam logic [DIV_W-1:0] ONE     = DIV_W'(1);
  localparam logic [DIV_W-1:0] DEF_DIV = DIV_W'(DEFAULT_DIV);
  localparam logic [DIV_W-1:0] DEF_CNT = DIV_W'(DEFAULT_DIV - 1);

  // Number of high cycles in a period of length d: ceil(d/2).
  // Divisors 0 and 1 degenerate to a constant-high output, so the
  // comparison threshold is forced to 1 for them.
  function automatic logic [DIV_W-1:0] high_len(input logic [DIV_W-1:0] d);
    if (d <= ONE) return ONE;
    return d - (d >> 1);
  endfunction

  logic [DIV_W-1:0]    div      [CHANNELS];
  logic [DIV_W-1:0]    cnt      [CHANNELS];
  logic [DIV_W-1:0]    pend_div [CHANNELS];
  logic [DIV_W-1:0]    div_nxt  [CHANNELS];
  logic [DIV_W-1:0]    cnt_nxt  [CHANNELS];
  logic [CHANNELS-1:0] wrap;
  logic [CHANNELS-1:0] sel;

  // Per-channel period boundary detection and next-state values.
  always_comb begin
    for (int i = 0; i < CHANNELS; i++) begin
      wrap[i]    = (div[i] <= ONE) || (cnt[i] == div[i] - ONE);
      div_nxt[i] = (wrap[i] && pending[i]) ? pend_div[i] : div[i];
      cnt_nxt[i] = wrap[i] ? '0 : cnt[i] + ONE;
      // Out-of-range load_ch values match no channel and are dropped here.
      sel[i]     = load && (int'(load_ch) == i);
    end
  end

  // Counter, divisor, pending-load and output registers for all channels.
  always_ff @(posedge clk_in or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < CHANNELS; i++) begin
        div[i]      <= DEF_DIV;
        cnt[i]      <= DEF_CNT;
        pend_div[i] <= '0;
      end
      clk_out <= '0;
      tick    <= '0;
      pending <= '0;
      leds    <= '0;
    end else begin
      for (int i = 0; i < CHANNELS; i++) begin
        if (en) begin
          cnt[i]     <= cnt_nxt[i];
          div[i]     <= div_nxt[i];
          clk_out[i] <= (cnt_nxt[i] < high_len(div_nxt[i]));
          tick[i]    <= wrap[i];
        end else begin
          tick[i]    <= 1'b0;
        end
        // A load on a wrap edge wins over the clear: the old pending value
        // is consumed by the wrap and the new one stays pending.
        if (sel[i]) begin
          pend_div[i] <= load_div;
          pending[i]  <= 1'b1;
        end else if (en && wrap[i]) begin
          pending[i]  <= 1'b0;
        end
      end
      if (en && wrap[0]) begin
        leds <= leds + LED_W'(1);
      end
    end
  end

endmodule

// File: tb/tb_clock_div_prog.sv
// Directed testbench for clock_div_prog: one task per scenario with
// hand-derived expected sequences. Three channels are instantiated so that
// load_ch is two bits wide and an out-of-range channel number exists.
module tb_clock_div_prog;

  localparam int CHANNELS = 3;
  localparam int DIV_W    = 16;
  localparam int LED_W    = 8;

  logic                clk_in   = 1'b0;
  logic                reset    = 1'b0;
  logic                en       = 1'b0;
  logic                load     = 1'b0;
  logic [1:0]          load_ch  = '0;
  logic [DIV_W-1:0]    load_div = '0;
  logic [CHANNELS-1:0] clk_out;
  logic [CHANNELS-1:0] tick;
  logic [CHANNELS-1:0] pending;
  logic [LED_W-1:0]    leds;

  int errors = 0;
  int checks = 0;

  clock_div_prog #(
    .CHANNELS(CHANNELS),
    .DIV_W(DIV_W),
    .DEFAULT_DIV(4),
    .LED_W(LED_W)
  ) dut (
    .clk_in(clk_in),
    .reset(reset),
    .en(en),
    .load(load),
    .load_ch(load_ch),
    .load_div(load_div),
    .clk_out(clk_out),
    .tick(tick),
    .pending(pending),
    .leds(leds)
  );

  always #5 clk_in = ~clk_in;

  initial begin
    #100000;
    $display("FAIL watchdog: time limit reached, checks=%0d", checks);
    $fatal(1, "watchdog expired");
  end

  // Advance past one rising edge; outputs are sampled on the falling edge.
  task automatic cyc();
    @(negedge clk_in);
  endtask

  // Pulse reset and release it so the next rising edge is enabled edge 1.
  task automatic restart();
    @(negedge clk_in);
    reset = 1'b0; load = 1'b0; load_ch = '0; en = 1'b1;
    @(negedge clk_in);
    reset = 1'b1;
  endtask

  task automatic test_reset();
    #12;
    if (clk_out !== '0) begin errors++; $display("FAIL reset_clk_out got %b want 000", clk_out); end
    checks++;
    if (tick !== '0) begin errors++; $display("FAIL reset_tick got %b want 000", tick); end
    checks++;
    if (pending !== '0) begin errors++; $display("FAIL reset_pending got %b want 000", pending); end
    checks++;
    if (leds !== '0) begin errors++; $display("FAIL reset_leds got %0d want 0", leds); end
    checks++;
    @(negedge clk_in);
    reset = 1'b1;
    en    = 1'b1;
    #1;
    if (clk_out !== '0) begin errors++; $display("FAIL release_clk_out got %b want 000", clk_out); end
    checks++;
  endtask

  task automatic test_default();
    logic ec, et;
    int   el;
    for (int k = 1; k <= 17; k++) begin
      cyc();
      ec = (((k - 1) % 4) < 2);
      et = (((k - 1) % 4) == 0);
      el = (k - 1) / 4 + 1;
      if (clk_out !== {CHANNELS{ec}}) begin
        errors++; $display("FAIL default_clk edge %0d got %b want %b", k, clk_out, {CHANNELS{ec}});
      end
      checks++;
      if (tick !== {CHANNELS{et}}) begin
        errors++; $display("FAIL default_tick edge %0d got %b want %b", k, tick, {CHANNELS{et}});
      end
      checks++;
      if (leds !== LED_W'(el)) begin
        errors++; $display("FAIL default_leds edge %0d got %0d want %0d", k, leds, el);
      end
      checks++;
    end
  endtask

  task automatic test_odd();
    logic ec [12];
    logic et [12];
    logic ep [12];
    ec = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0};
    et = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0};
    ep = '{1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0};
    restart();
    cyc();
    load = 1'b1; load_ch = 2'd1; load_div = 16'd3;
    for (int i = 0; i < 12; i++) begin
      cyc();
      load = 1'b0;
      if (clk_out[1] !== ec[i]) begin
        errors++; $display("FAIL odd_clk edge %0d got %b want %b", i + 2, clk_out[1], ec[i]);
      end
      checks++;
      if (tick[1] !== et[i]) begin
        errors++; $display("FAIL odd_tick edge %0d got %b want %b", i + 2, tick[1], et[i]);
      end
      checks++;
      if (pending[1] !== ep[i]) begin
        errors++; $display("FAIL odd_pending edge %0d got %b want %b", i + 2, pending[1], ep[i]);
      end
      checks++;
    end
  endtask

  task automatic test_degenerate();
    restart();
    cyc();
    load = 1'b1; load_ch = 2'd0; load_div = 16'd1;
    for (int k = 2; k <= 260; k++) begin
      cyc();
      load = 1'b0;
      if (k == 6) begin
        if (pending[0] !== 1'b1) begin errors++; $display("FAIL degen_pending0 got %b want 1", pending[0]); end
        checks++;
      end
      if (k == 7) begin
        if (pending[0] !== 1'b0) begin errors++; $display("FAIL degen_pending_clear got %b want 0", pending[0]); end
        checks++;
      end
      if (k >= 5) begin
        if (clk_out[0] !== 1'b1) begin
          errors++; $display("FAIL degen_clk edge %0d got %b want 1", k, clk_out[0]);
        end
        checks++;
        if (tick[0] !== 1'b1) begin
          errors++; $display("FAIL degen_tick edge %0d got %b want 1", k, tick[0]);
        end
        checks++;
        if (leds !== LED_W'(k - 3)) begin
          errors++; $display("FAIL degen_leds edge %0d got %0d want %0d", k, leds, (k - 3) % 256);
        end
        checks++;
      end
      if (k == 5) begin
        load = 1'b1; load_ch = 2'd0; load_div = 16'd0;
      end
    end
  endtask

  task automatic test_enable_load();
    logic ec [11];
    logic et [11];
    logic ep [11];
    int   el [11];
    ec = '{1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1};
    et = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1};
    ep = '{1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0};
    el = '{1, 1, 2, 2, 2, 2, 2, 2, 2, 2, 3};
    restart();
    cyc();
    cyc();
    en = 1'b0;
    for (int k = 3; k <= 9; k++) begin
      cyc();
      load = 1'b0;
      if (clk_out !== 3'b111) begin
        errors++; $display("FAIL frozen_clk edge %0d got %b want 111", k, clk_out);
      end
      checks++;
      if (tick !== 3'b000) begin
        errors++; $display("FAIL frozen_tick edge %0d got %b want 000", k, tick);
      end
      checks++;
      if (leds !== 8'd1) begin
        errors++; $display("FAIL frozen_leds edge %0d got %0d want 1", k, leds);
      end
      checks++;
      if (pending[0] !== (k >= 4)) begin
        errors++; $display("FAIL frozen_pending edge %0d got %b want %b", k, pending[0], (k >= 4));
      end
      checks++;
      if (k == 3) begin load = 1'b1; load_ch = 2'd0; load_div = 16'd6; end
      if (k == 5) begin load = 1'b1; load_ch = 2'd0; load_div = 16'd8; end
    end
    en = 1'b1;
    for (int i = 0; i < 11; i++) begin
      cyc();
      if (clk_out[0] !== ec[i]) begin
        errors++; $display("FAIL resume_clk edge %0d got %b want %b", i + 10, clk_out[0], ec[i]);
      end
      checks++;
      if (tick[0] !== et[i]) begin
        errors++; $display("FAIL resume_tick edge %0d got %b want %b", i + 10, tick[0], et[i]);
      end
      checks++;
      if (pending[0] !== ep[i]) begin
        errors++; $display("FAIL resume_pending edge %0d got %b want %b", i + 10, pending[0], ep[i]);
      end
      checks++;
      if (leds !== LED_W'(el[i])) begin
        errors++; $display("FAIL resume_leds edge %0d got %0d want %0d", i + 10, leds, el[i]);
      end
      checks++;
    end
  endtask

  task automatic test_coincident();
    logic ec [10];
    logic et [10];
    logic ep [10];
    ec = '{1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0};
    et = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0};
    ep = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0};
    restart();
    cyc();
    load = 1'b1; load_ch = 2'd0; load_div = 16'd6;
    cyc();
    load = 1'b0;
    cyc();
    cyc();
    load = 1'b1; load_ch = 2'd0; load_div = 16'd2;
    for (int i = 0; i < 10; i++) begin
      cyc();
      load = 1'b0;
      if (clk_out[0] !== ec[i]) begin
        errors++; $display("FAIL coinc_clk edge %0d got %b want %b", i + 5, clk_out[0], ec[i]);
      end
      checks++;
      if (tick[0] !== et[i]) begin
        errors++; $display("FAIL coinc_tick edge %0d got %b want %b", i + 5, tick[0], et[i]);
      end
      checks++;
      if (pending[0] !== ep[i]) begin
        errors++; $display("FAIL coinc_pending edge %0d got %b want %b", i + 5, pending[0], ep[i]);
      end
      checks++;
    end
  endtask

  task automatic test_bad_channel();
    logic ec, et;
    restart();
    cyc();
    load = 1'b1; load_ch = 2'd3; load_div = 16'd7;
    for (int k = 2; k <= 9; k++) begin
      cyc();
      load = 1'b0; load_ch = 2'd0;
      ec = (((k - 1) % 4) < 2);
      et = (((k - 1) % 4) == 0);
      if (pending !== 3'b000) begin
        errors++; $display("FAIL badch_pending edge %0d got %b want 000", k, pending);
      end
      checks++;
      if (clk_out !== {CHANNELS{ec}}) begin
        errors++; $display("FAIL badch_clk edge %0d got %b want %b", k, clk_out, {CHANNELS{ec}});
      end
      checks++;
      if (tick !== {CHANNELS{et}}) begin
        errors++; $display("FAIL badch_tick edge %0d got %b want %b", k, tick, {CHANNELS{et}});
      end
      checks++;
    end
  endtask

  task automatic test_async_reset();
    logic ec, et;
    restart();
    for (int k = 1; k <= 4; k++) cyc();
    load = 1'b1; load_ch = 2'd0; load_div = 16'd6;
    cyc();
    load = 1'b0;
    if (clk_out[0] !== 1'b1) begin errors++; $display("FAIL pre_rst_clk got %b want 1", clk_out[0]); end
    checks++;
    if (tick[0] !== 1'b1) begin errors++; $display("FAIL pre_rst_tick got %b want 1", tick[0]); end
    checks++;
    if (pending[0] !== 1'b1) begin errors++; $display("FAIL pre_rst_pending got %b want 1", pending[0]); end
    checks++;
    if (leds !== 8'd2) begin errors++; $display("FAIL pre_rst_leds got %0d want 2", leds); end
    checks++;
    #2;
    reset = 1'b0;
    #1;
    if (clk_out !== '0) begin errors++; $display("FAIL async_clk got %b want 000", clk_out); end
    checks++;
    if (tick !== '0) begin errors++; $display("FAIL async_tick got %b want 000", tick); end
    checks++;
    if (pending !== '0) begin errors++; $display("FAIL async_pending got %b want 000", pending); end
    checks++;
    if (leds !== '0) begin errors++; $display("FAIL async_leds got %0d want 0", leds); end
    checks++;
    @(negedge clk_in);
    reset = 1'b1;
    for (int k = 1; k <= 9; k++) begin
      cyc();
      ec = (((k - 1) % 4) < 2);
      et = (((k - 1) % 4) == 0);
      if (clk_out[0] !== ec) begin
        errors++; $display("FAIL post_rst_clk edge %0d got %b want %b", k, clk_out[0], ec);
      end
      checks++;
      if (tick[0] !== et) begin
        errors++; $display("FAIL post_rst_tick edge %0d got %b want %b", k, tick[0], et);
      end
      checks++;
      if (pending[0] !== 1'b0) begin
        errors++; $display("FAIL post_rst_pending edge %0d got %b want 0", k, pending[0]);
      end
      checks++;
    end
  endtask

  initial begin
    test_reset();
    test_default();
    test_odd();
    test_degenerate();
    test_enable_load();
    test_coincident();
    test_bad_channel();
    test_async_reset();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
